// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter for the register file write port with pending-write scoreboard
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_rd,
    output logic [DATA_W-1:0]         rf_wdata,
    input  logic                      sb_set_valid,
    input  logic [ADDR_W-1:0]         sb_set_rd,
    input  logic [ADDR_W-1:0]         rs1,
    input  logic [ADDR_W-1:0]         rs2,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic                      sb_err
);

    localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NUM_REGS = 1 << ADDR_W;

    logic [PTR_W-1:0]    ptr;
    logic [PTR_W:0]      scan_sum;
    logic [PTR_W-1:0]    scan_idx;
    logic [PTR_W-1:0]    gnt_idx;
    logic                gnt_any;
    logic [ADDR_W-1:0]   gnt_rd;
    logic [DATA_W-1:0]   gnt_data;
    logic                gnt_write;

    logic [NUM_REGS-1:0] sb;
    logic [NUM_REGS-1:0] sb_next;
    logic                set_en;
    logic                clr_hit;

    // Round-robin scan: first valid requester at or after ptr, wrapping modulo NUM_REQ
    always_comb begin
        scan_sum = '0;
        scan_idx = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (!gnt_any && req_valid[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    // One-hot ready and selection of the winner's index and data slices
    always_comb begin
        req_ready = '0;
        gnt_rd    = '0;
        gnt_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_any && (gnt_idx == PTR_W'(i))) begin
                req_ready[i] = 1'b1;
                gnt_rd       = req_rd[i*ADDR_W +: ADDR_W];
                gnt_data     = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Writes to x0 are consumed but never reach the register file
    assign gnt_write = gnt_any && (gnt_rd != '0);

    // Pointer moves just past the requester that completed a handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Commit register: one rf_we pulse the cycle after each non-x0 handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= gnt_write;
            if (gnt_write) begin
                rf_rd    <= gnt_rd;
                rf_wdata <= gnt_data;
            end
        end
    end

    assign set_en  = sb_set_valid && (sb_set_rd != '0);
    assign clr_hit = rf_we && (rf_rd == sb_set_rd);

    // Scoreboard next state: commit clears, issue sets, set wins on collision, x0 never busy
    always_comb begin
        sb_next = sb;
        if (rf_we) begin
            sb_next[rf_rd] = 1'b0;
        end
        if (set_en) begin
            sb_next[sb_set_rd] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    // Scoreboard state and sticky error for issuing onto a register still pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb     <= '0;
            sb_err <= 1'b0;
        end else begin
            sb <= sb_next;
            if (set_en && sb[sb_set_rd] && !clr_hit) begin
                sb_err <= 1'b1;
            end
        end
    end

    assign rs1_busy = sb[rs1];
    assign rs2_busy = sb[rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench with random stimulus and reference model for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 64;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_rd;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              rf_we;
    logic [AW-1:0]     rf_rd;
    logic [DW-1:0]     rf_wdata;
    logic              sb_set_valid;
    logic [AW-1:0]     sb_set_rd;
    logic [AW-1:0]     rs1;
    logic [AW-1:0]     rs2;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              sb_err;

    regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .sb_set_valid(sb_set_valid), .sb_set_rd(sb_set_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .sb_err(sb_err)
    );

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          q[$];
    int            gnt_hist[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    bit            mon_en = 0;

    // reference model state
    logic [N-1:0]  pend;
    logic [AW-1:0] prd [N];
    logic [DW-1:0] pdata [N];
    logic [31:0]   msb;
    bit            merr;
    int            mptr;
    bit            mcw;
    logic [AW-1:0] mcrd;

    // stimulus requested for the next cycle
    logic [N-1:0]  nmask;
    logic [AW-1:0] nrd [N];
    logic [DW-1:0] ndata [N];
    logic          s_v;
    logic [AW-1:0] s_rd;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rf_we pulse must match the oldest expected write, in its cycle
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (rf_we === 1'b1) begin
                if (q.size() == 0) begin
                    chk("rf_we_spurious", 64'(rf_we), 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rf_rd", 64'(rf_rd), 64'(e.rd));
                    chk("rf_wdata", rf_wdata, e.data);
                    chk("rf_we_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                chk("rf_we_missing", 64'(rf_we), 64'd1);
                void'(q.pop_front());
            end
        end
    end

    task automatic do_reset();
        mon_en       = 0;
        rst_n        = 1'b0;
        req_valid    = '0;
        req_rd       = '0;
        req_data     = '0;
        sb_set_valid = 1'b0;
        sb_set_rd    = '0;
        nmask        = '0;
        s_v          = 1'b0;
        pend         = '0;
        msb          = '0;
        merr         = 0;
        mptr         = 0;
        mcw          = 0;
        q.delete();
        gnt_hist.delete();
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1;
    endtask

    // One clock cycle: drive, check against the model, advance the model past the edge
    task automatic step();
        int g;
        logic [N-1:0] exp_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && nmask[i]) begin
                pend[i]  = 1'b1;
                prd[i]   = nrd[i];
                pdata[i] = ndata[i];
            end
            req_valid[i]           = pend[i];
            req_rd[i*AW +: AW]     = prd[i];
            req_data[i*DW +: DW]   = pdata[i];
        end
        sb_set_valid = s_v;
        sb_set_rd    = s_rd;
        rs1          = r1;
        rs2          = r2;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && pend[(mptr + k) % N]) g = (mptr + k) % N;
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("rs1_busy", 64'(rs1_busy), 64'(msb[r1]));
        chk("rs2_busy", 64'(rs2_busy), 64'(msb[r2]));
        chk("sb_err", 64'(sb_err), 64'(merr));
        if (s_v && s_rd != 0 && msb[s_rd] && !(mcw && mcrd == s_rd)) merr = 1;
        if (mcw) msb[mcrd] = 1'b0;
        if (s_v && s_rd != 0) msb[s_rd] = 1'b1;
        mcw = 0;
        if (g >= 0) begin
            gnt_hist.push_back(g);
            mptr    = (g + 1) % N;
            pend[g] = 1'b0;
            if (prd[g] != 0) begin
                q.push_back('{rd: prd[g], data: pdata[g], cyc: cyc + 1});
                mcw  = 1;
                mcrd = prd[g];
            end
        end
    endtask

    int rr_exp [6] = '{0, 1, 2, 0, 1, 2};
    int w2;

    initial begin
        for (int i = 0; i < N; i++) begin
            prd[i] = '0; pdata[i] = '0; nrd[i] = '0; ndata[i] = '0;
        end
        r1 = '0; r2 = '0; s_rd = '0;
        rs1 = '0; rs2 = '0;
        do_reset();

        // reset state and idle
        chk("reset_rf_we", 64'(rf_we), 64'd0);
        chk("reset_rf_rd", 64'(rf_rd), 64'd0);
        chk("reset_rf_wdata", rf_wdata, 64'd0);
        chk("reset_sb_err", 64'(sb_err), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        repeat (4) step();

        // single write to x5 with busy tracking
        r1 = 5; s_v = 1; s_rd = 5;
        step();
        s_v = 0;
        nmask = 3'b001; nrd[0] = 5; ndata[0] = 64'hDEAD_BEEF;
        step();
        nmask = '0;
        step();
        chk("single_rf_we", 64'(rf_we), 64'd1);
        chk("single_rf_rd", 64'(rf_rd), 64'd5);
        chk("single_rf_wdata", rf_wdata, 64'hDEAD_BEEF);
        chk("single_busy_during", 64'(rs1_busy), 64'd1);
        step();
        chk("single_busy_after", 64'(rs1_busy), 64'd0);

        // reset in the middle of an in-flight commit
        s_v = 1; s_rd = 5;
        step();
        s_v = 0;
        nmask = 3'b001; nrd[0] = 5; ndata[0] = 64'h55;
        step();
        nmask = '0;
        @(posedge clk);
        #1;
        mon_en = 0;
        chk("inflight_rf_we", 64'(rf_we), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_rf_we", 64'(rf_we), 64'd0);
        chk("async_rst_busy", 64'(rs1_busy), 64'd0);
        do_reset();

        // round-robin with all requesters valid
        nmask = 3'b111;
        for (int i = 0; i < N; i++) begin
            nrd[i] = AW'(i + 1); ndata[i] = {$urandom, $urandom};
        end
        repeat (6) step();
        nmask = '0;
        repeat (2) step();
        for (int i = 0; i < 6; i++) begin
            chk("rr_order", 64'(gnt_hist.size() > i ? gnt_hist[i] : -1), 64'(rr_exp[i]));
        end

        // fairness: req0 always valid, req2 joins later
        do_reset();
        w2 = 0;
        for (int c = 0; c < 8; c++) begin
            nmask = (c >= 2) ? 3'b101 : 3'b001;
            nrd[0] = 10; nrd[2] = 12;
            ndata[0] = {$urandom, $urandom}; ndata[2] = {$urandom, $urandom};
            step();
            if (pend[2]) w2++; else w2 = 0;
            chk("req2_wait_le2", 64'(w2 <= 2), 64'd1);
        end
        nmask = '0;
        repeat (2) step();

        // x0 write is consumed and advances the pointer
        do_reset();
        nmask = 3'b001; nrd[0] = 0; ndata[0] = 64'h1234;
        step();
        nmask = '0; s_v = 1; s_rd = 0; r1 = 0;
        step();
        s_v = 0;
        step();
        chk("x0_busy", 64'(rs1_busy), 64'd0);
        nmask = 3'b011; nrd[0] = 3; nrd[1] = 4;
        step();
        chk("x0_ptr_adv", 64'(gnt_hist[gnt_hist.size()-1]), 64'd1);
        nmask = '0;
        repeat (3) step();

        // set and commit on the same register at the same edge; double set error
        do_reset();
        s_v = 1; s_rd = 7;
        step();
        s_v = 0;
        nmask = 3'b001; nrd[0] = 7; ndata[0] = 64'h77;
        step();
        nmask = '0; s_v = 1; s_rd = 7;
        step();
        s_v = 0; r1 = 7;
        step();
        chk("set_wins_busy", 64'(rs1_busy), 64'd1);
        chk("set_wins_no_err", 64'(sb_err), 64'd0);
        s_v = 1; s_rd = 9;
        repeat (2) step();
        s_v = 0;
        step();
        chk("double_set_err", 64'(sb_err), 64'd1);
        repeat (3) step();
        chk("err_sticky", 64'(sb_err), 64'd1);
        do_reset();
        chk("err_cleared", 64'(sb_err), 64'd0);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            nmask = N'($urandom);
            for (int i = 0; i < N; i++) begin
                nrd[i]   = AW'($urandom_range(0, 7));
                ndata[i] = {$urandom, $urandom};
            end
            s_rd = AW'($urandom_range(0, 7));
            s_v  = ($urandom_range(0, 2) == 0) && !msb[s_rd];
            r1   = AW'($urandom_range(0, 7));
            r2   = AW'($urandom_range(0, 7));
            step();
        end
        nmask = '0; s_v = 0;
        repeat (4) step();
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single write port of the 32x64 register file between NUM_REQ writeback sources (e.g. ALU, load unit, multiplier) using round-robin arbitration with valid/ready handshakes. The winning write is registered and driven onto the register file's write-enable, destination-index and write-data inputs one cycle after grant. A per-register pending-write scoreboard sits alongside, set by decode at issue and cleared at commit. Decode uses its rs1_busy/rs2_busy outputs to stall RAW hazards.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
DATA_W, 64, register data width
ADDR_W, 5, register index width (32 registers)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  requester i has a write pending
req_rd  input  NUM_REQ*ADDR_W  packed destination index, slice i for requester i
req_data  input  NUM_REQ*DATA_W  packed write data, slice i for requester i
req_ready  output  NUM_REQ  one-hot grant; handshake when req_valid[i]&&req_ready[i]
rf_we  output  1  register file write enable (RegWrite)
rf_rd  output  ADDR_W  register file destination index
rf_wdata  output  DATA_W  register file write data
sb_set_valid  input  1  decode issues an instruction writing sb_set_rd
sb_set_rd  input  ADDR_W  destination index being issued
rs1  input  ADDR_W  decode source index 1
rs2  input  ADDR_W  decode source index 2
rs1_busy  output  1  scoreboard bit of rs1 (combinational)
rs2_busy  output  1  scoreboard bit of rs2 (combinational)
sb_err  output  1  sticky: illegal set on an already-busy register

Behaviour:
- Reset (rst_n low, async): rf_we=0, rf_rd=0, rf_wdata=0, all scoreboard bits 0, rr pointer=0, sb_err=0. req_ready is combinational and therefore 0 while no requester is valid. Reset mid-transfer drops the in-flight registered write (rf_we forced 0 immediately).
- Arbitration (combinational): search starts at index ptr, wrapping modulo NUM_REQ. The first i with req_valid[i]=1 gets req_ready[i]=1. At most one ready bit is set. req_ready=0 when no valid.
- Pointer: on a handshake by requester g, ptr <= (g+1) mod NUM_REQ. No handshake leaves ptr unchanged. Wrap from NUM_REQ-1 to 0.
- Requester rule: once req_valid[i] is raised, req_rd/req_data slice i holds stable until the handshake. The arbiter never grants a non-valid requester.
- Commit register: a handshake at edge t drives rf_we=1, rf_rd=req_rd[g] and rf_wdata=req_data[g] during cycle t+1. The register file writes on the edge ending cycle t+1. rf_we is a one-cycle pulse per handshake. Back-to-back grants give back-to-back pulses, at full throughput of one write per cycle.
- x0: a handshake with req_rd=0 is consumed (ready given, ptr advances), but rf_we stays 0 and rf_rd/rf_wdata hold their previous values.
- Scoreboard, 32 bits:
  - Bit rd is set at the edge where sb_set_valid=1 and sb_set_rd!=0. Bit 0 is always 0.
  - Bit rf_rd is cleared at the edge ending a cycle with rf_we=1.
  - If set and clear hit the same rd on the same edge, set wins.
  - sb_set_valid on an rd whose bit is already 1 and not clearing this edge sets sb_err=1 (sticky until reset). The bit stays 1.
- rs1_busy = sb[rs1], rs2_busy = sb[rs2]. Both are 0 for index 0. No same-cycle bypass: the bit reflects the registered state, so it drops the cycle after the commit edge.

Test Plan:
- Reset then idle: rst_n low mid-cycle -> rf_we=0 and rs1_busy=0 immediately; all req_valid=0 -> req_ready=000, rf_we never pulses.
- Single write: sb_set rd=5, then req_valid=001, rd=5, data=0xDEAD_BEEF -> req_ready=001 same cycle; next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF; rs1=5 shows busy=1 until the edge after the rf_we cycle, then 0.
- Round-robin: req_valid=111 held for 6 cycles, ptr=0 -> grant order 0,1,2,0,1,2; six consecutive rf_we pulses with matching rd/data.
- Fairness under contention: req0 always valid, req2 valid from cycle 2 -> req2 is granted within 2 cycles; req0 is never granted twice while req2 waits.
- x0 write: req_rd=0, data=0x1234 -> handshake occurs, ptr advances, rf_we stays 0; sb_set rd=0 leaves rs1_busy(rs1=0)=0.
- Scoreboard corners: set rd=7 on the same edge as rf_we commits rd=7 -> bit stays 1; set rd=9 twice without a commit -> sb_err=1 and stays 1 until rst_n.
